// File: rtl/lfsr_if.sv
// Bus between the LFSR burst generator and its consumer: seed in, serial bit
// and valid strobe out.
interface lfsr_if;
  logic [3:0] seed;
  logic       OUT;
  logic       Valid;

  modport master (
    output seed,
    input  OUT,
    input  Valid
  );

  modport slave (
    input  seed,
    output OUT,
    output Valid
  );
endinterface

// File: rtl/lfsr.sv
// 4-bit Fibonacci LFSR: scrambles the seed for SHIFT_CYCLES steps after reset,
// then emits one 4-bit burst LSB first with a Valid strobe and goes idle.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_SHIFT  | one LFSR step per edge, outputs idle, counts SHIFT_CYCLES
//   S_OUTPUT | shift r[0] out on each edge with Valid=1, four bits total
//   S_DONE   | burst finished, outputs idle until the next reset
module lfsr #(
  parameter int SHIFT_CYCLES = 8
) (
  input  logic  CLK,
  input  logic  RST,
  lfsr_if.slave bus
);

  localparam int MAX_COUNT = (SHIFT_CYCLES > 4) ? SHIFT_CYCLES : 4;
  localparam int CW        = $clog2(MAX_COUNT);

  localparam logic [CW-1:0] LAST_SHIFT = CW'(SHIFT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(3);

  typedef enum logic [1:0] {
    S_SHIFT  = 2'd0,
    S_OUTPUT = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          valid_q, valid_d;

  // Reset reloads the seed on every low edge, so an abort mid-burst restarts cleanly.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_q     <= bus.seed;
      cnt_q   <= '0;
      state_q <= S_SHIFT;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    r_d     = r_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    out_d   = 1'b0;
    valid_d = 1'b0;

    unique case (state_q)
      S_SHIFT: begin
        // Taps on bits 0 and 1 give the maximal period of 15.
        r_d = {r_q[0] ^ r_q[1], r_q[3:1]};
        if (cnt_q == LAST_SHIFT) begin
          cnt_d   = '0;
          state_d = S_OUTPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        out_d   = r_q[0];
        valid_d = 1'b1;
        r_d     = {1'b0, r_q[3:1]};
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  assign bus.OUT   = out_q;
  assign bus.Valid = valid_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for the lfsr burst generator: hand-computed bursts for several
// seeds, reset abort mid-burst, and seed changes ignored outside reset.
module tb_lfsr;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  lfsr_if bus ();

  lfsr #(.SHIFT_CYCLES(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #50 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive RST low for one edge with the given seed, check the reset state,
  // then release RST away from the clock edge.
  task automatic reset_pulse(input logic [3:0] s, input string tag);
    @(negedge CLK);
    bus.seed = s;
    RST      = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_rst_valid"}, bus.Valid, 1'b0);
    check({tag, "_rst_out"},   bus.OUT,   1'b0);
    RST = 1'b1;
  endtask

  // Follow edges 1..15 after release: idle for 1..8, bits on 9..12, idle after.
  task automatic burst(input string tag, input logic [3:0] bits);
    for (int e = 1; e <= 15; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (e >= 9 && e <= 12) begin
        check($sformatf("%s_e%0d_valid", tag, e), bus.Valid, 1'b1);
        check($sformatf("%s_e%0d_out", tag, e),   bus.OUT,   bits[e-9]);
      end else begin
        check($sformatf("%s_e%0d_valid", tag, e), bus.Valid, 1'b0);
        check($sformatf("%s_e%0d_out", tag, e),   bus.OUT,   1'b0);
      end
    end
  endtask

  initial begin
    bus.seed = 4'b0000;

    // seed 1001 scrambles to 1111
    reset_pulse(4'b1001, "s1001");
    burst("s1001", 4'b1111);

    // seed 0001 scrambles to 0101 -> bits 1,0,1,0
    reset_pulse(4'b0001, "s0001");
    burst("s0001", 4'b0101);

    // abort on the second output bit, then the full burst repeats
    reset_pulse(4'b1001, "abort");
    for (int e = 1; e <= 9; e++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("abort_e9_valid", bus.Valid, 1'b1);
    check("abort_e9_out",   bus.OUT,   1'b1);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_e10_valid", bus.Valid, 1'b0);
    check("abort_e10_out",   bus.OUT,   1'b0);
    RST = 1'b1;
    burst("abort_rerun", 4'b1111);

    // all-zero seed: four zero bits still strobed
    reset_pulse(4'b0000, "s0000");
    burst("s0000", 4'b0000);

    // seed changed after release must not disturb the 1001 burst
    reset_pulse(4'b1001, "seedchg");
    bus.seed = 4'b0001;
    burst("seedchg", 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
